// File: rtl/am2301_sample_manager.sv
// AM2301 sample manager: paces sensor reads, watches for a response, validates the
// 40-bit frame and publishes temperature/humidity plus status over an Avalon-MM slave.
`timescale 1ns/1ps

module am2301_sample_manager #(
    parameter int TICKS_PER_MS   = 50000,
    parameter int DEFAULT_PERIOD = 2000,
    parameter int MIN_PERIOD     = 2000,
    parameter int TIMEOUT_MS     = 20
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    output logic        coe_start,
    input  logic        coe_busy,
    input  logic        coe_frame_valid,
    input  logic [39:0] coe_frame_data,
    input  logic [1:0]  avs_ctrl_address,
    input  logic        avs_ctrl_read,
    input  logic        avs_ctrl_write,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    output logic        ins_irq
);

    localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK
    } state_t;

    state_t        state, state_next;

    logic [PW-1:0] pre_cnt;
    logic          ms_tick;
    logic [15:0]   period_cnt;
    logic          period_hit;
    logic [15:0]   to_ms;
    logic          to_hit;

    logic [39:0]   frame_q;
    logic [7:0]    csum;
    logic          set_valid;
    logic          set_crc;
    logic          set_timeout;
    logic [15:0]   temp_mag;
    logic [15:0]   temp_2c;

    logic [31:0]   data_reg;
    logic          valid;
    logic          crc_err;
    logic          timeout_flag;
    logic [7:0]    crc_cnt;
    logic [7:0]    timeout_cnt;
    logic          enable;
    logic          irq_en;
    logic [15:0]   period_reg;
    logic [15:0]   period_wr;
    logic [31:0]   status_word;

    logic          wr_status;
    logic          wr_ctrl;
    logic          wr_period;
    logic          rd_data;
    logic          trigger;
    logic          clr_counters;
    logic          unused_wd;

    assign wr_status    = avs_ctrl_write && (avs_ctrl_address == 2'd1);
    assign wr_ctrl      = avs_ctrl_write && (avs_ctrl_address == 2'd2);
    assign wr_period    = avs_ctrl_write && (avs_ctrl_address == 2'd3);
    assign rd_data      = avs_ctrl_read  && (avs_ctrl_address == 2'd0);
    assign trigger      = wr_ctrl && avs_ctrl_writedata[2];
    assign clr_counters = wr_status && avs_ctrl_writedata[31];
    assign unused_wd    = ^avs_ctrl_writedata[30:16];

    assign ms_tick = (pre_cnt == PW'(TICKS_PER_MS - 1));

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset || ms_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    // The pacing counter only advances while idle, so time spent acquiring stretches the period.
    assign period_hit = enable && (state == S_IDLE) && ms_tick &&
                        (({1'b0, period_cnt} + 17'd1) >= {1'b0, period_reg});

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset || !enable) begin
            period_cnt <= '0;
        end else if ((state == S_IDLE) && ms_tick) begin
            period_cnt <= period_hit ? 16'd0 : period_cnt + 16'd1;
        end
    end

    assign to_hit = (state == S_WAIT) && ms_tick && (to_ms == 16'(TIMEOUT_MS - 1));

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset || (state == S_START)) begin
            to_ms <= '0;
        end else if ((state == S_WAIT) && ms_tick) begin
            to_ms <= to_ms + 16'd1;
        end
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A frame arriving in the same cycle as the watchdog expiry takes priority.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (period_hit || trigger) state_next = S_START;
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (coe_frame_valid) begin
                    state_next = S_CHECK;
                end else if (to_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_CHECK: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign coe_start = (state == S_START);

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            frame_q <= '0;
        end else if ((state == S_WAIT) && coe_frame_valid) begin
            frame_q <= coe_frame_data;
        end
    end

    assign csum        = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];
    assign set_valid   = (state == S_CHECK) && (csum == frame_q[7:0]);
    assign set_crc     = (state == S_CHECK) && (csum != frame_q[7:0]);
    assign set_timeout = to_hit && !coe_frame_valid;

    // Sign-magnitude to two's complement; negative zero collapses to 0.
    assign temp_mag = {1'b0, frame_q[22:8]};
    assign temp_2c  = frame_q[23] ? (16'd0 - temp_mag) : temp_mag;

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            data_reg     <= '0;
            valid        <= 1'b0;
            crc_err      <= 1'b0;
            timeout_flag <= 1'b0;
            crc_cnt      <= '0;
            timeout_cnt  <= '0;
        end else begin
            if (set_valid) begin
                data_reg <= {temp_2c, frame_q[39:24]};
            end

            if (set_valid) begin
                valid <= 1'b1;
            end else if (rd_data || (wr_status && avs_ctrl_writedata[0])) begin
                valid <= 1'b0;
            end

            if (set_crc) begin
                crc_err <= 1'b1;
            end else if (wr_status && avs_ctrl_writedata[1]) begin
                crc_err <= 1'b0;
            end

            if (set_timeout) begin
                timeout_flag <= 1'b1;
            end else if (wr_status && avs_ctrl_writedata[2]) begin
                timeout_flag <= 1'b0;
            end

            if (clr_counters) begin
                crc_cnt <= set_crc ? 8'd1 : 8'd0;
            end else if (set_crc && (crc_cnt != 8'hFF)) begin
                crc_cnt <= crc_cnt + 8'd1;
            end

            if (clr_counters) begin
                timeout_cnt <= set_timeout ? 8'd1 : 8'd0;
            end else if (set_timeout && (timeout_cnt != 8'hFF)) begin
                timeout_cnt <= timeout_cnt + 8'd1;
            end
        end
    end

    assign period_wr = (avs_ctrl_writedata[15:0] < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD)
                                                                    : avs_ctrl_writedata[15:0];

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            enable     <= 1'b0;
            irq_en     <= 1'b0;
            period_reg <= 16'(DEFAULT_PERIOD);
        end else begin
            if (wr_ctrl) begin
                enable <= avs_ctrl_writedata[0];
                irq_en <= avs_ctrl_writedata[1];
            end
            if (wr_period) begin
                period_reg <= period_wr;
            end
        end
    end

    assign status_word = {8'd0, timeout_cnt, crc_cnt, 3'd0, (state != S_IDLE),
                          coe_busy, timeout_flag, crc_err, valid};

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            avs_ctrl_readdata <= '0;
            ins_irq           <= 1'b0;
        end else begin
            if (avs_ctrl_read) begin
                case (avs_ctrl_address)
                    2'd0:    avs_ctrl_readdata <= data_reg;
                    2'd1:    avs_ctrl_readdata <= status_word;
                    2'd2:    avs_ctrl_readdata <= {30'd0, irq_en, enable};
                    default: avs_ctrl_readdata <= {16'd0, period_reg};
                endcase
            end
            ins_irq <= irq_en && (valid || crc_err || timeout_flag);
        end
    end

endmodule

// File: tb/tb_am2301_sample_manager.sv
// Directed bench for am2301_sample_manager: register access, frame handling,
// watchdog, pacing, interrupt and mid-acquisition reset.
`timescale 1ns/1ps

module tb_am2301_sample_manager;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_PERIOD = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        coe_start;
    logic        coe_busy = 1'b0;
    logic        frame_valid = 1'b0;
    logic [39:0] frame_data = '0;
    logic [1:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int start_count = 0;
    int start_times[$];

    am2301_sample_manager #(
        .TICKS_PER_MS  (10),
        .DEFAULT_PERIOD(2000),
        .MIN_PERIOD    (2),
        .TIMEOUT_MS    (20)
    ) dut (
        .csi_MCLK_clk      (clk),
        .rsi_MRST_reset    (reset),
        .coe_start         (coe_start),
        .coe_busy          (coe_busy),
        .coe_frame_valid   (frame_valid),
        .coe_frame_data    (frame_data),
        .avs_ctrl_address  (address),
        .avs_ctrl_read     (read),
        .avs_ctrl_write    (write),
        .avs_ctrl_writedata(writedata),
        .avs_ctrl_readdata (readdata),
        .ins_irq           (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (coe_start) begin
            start_count++;
            start_times.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] time limit expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick(1);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        tick(1);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        int c0;
        c0 = start_count;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick(1);
            if (start_count != c0) seen = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [39:0] f);
        frame_data = f; frame_valid = 1'b1;
        tick(1);
        frame_valid = 1'b0;
        tick(1);
    endtask

    task automatic acquire(input logic [39:0] f, input logic [31:0] ctrl_keep);
        bit seen;
        bus_write(A_CTRL, ctrl_keep | 32'h4);
        wait_start(5, seen);
        vecs++;
        if (seen !== 1'b1) begin
            $display("[TB] FAIL acquire_start: got no coe_start, expected pulse within 5 cycles");
            errs++;
        end
        send_frame(f);
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        tick(3);
        vecs++; if (coe_start !== 1'b0) begin $display("[TB] FAIL reset_start: got %b expected 0", coe_start); errs++; end
        vecs++; if (irq !== 1'b0) begin $display("[TB] FAIL reset_irq: got %b expected 0", irq); errs++; end
        reset = 1'b0;
        tick(1);
        bus_read(A_DATA, rd);
        vecs++; if (rd !== 32'h0) begin $display("[TB] FAIL reset_data: got %h expected 00000000", rd); errs++; end
        bus_read(A_STATUS, rd);
        vecs++; if (rd !== 32'h0) begin $display("[TB] FAIL reset_status: got %h expected 00000000", rd); errs++; end
        bus_read(A_CTRL, rd);
        vecs++; if (rd !== 32'h0) begin $display("[TB] FAIL reset_ctrl: got %h expected 00000000", rd); errs++; end
        bus_read(A_PERIOD, rd);
        vecs++; if (rd !== 32'd2000) begin $display("[TB] FAIL reset_period: got %0d expected 2000", rd); errs++; end
    endtask

    task automatic test_valid_frame;
        logic [31:0] rd;
        bit seen;
        int c0;
        c0 = start_count;
        bus_write(A_CTRL, 32'h4);
        wait_start(5, seen);
        vecs++; if (seen !== 1'b1) begin $display("[TB] FAIL trig_start: got no pulse expected coe_start"); errs++; end
        vecs++; if (coe_start !== 1'b0 || start_count - c0 != 1) begin
            $display("[TB] FAIL start_width: got %0d high cycles expected 1", start_count - c0); errs++; end
        send_frame(40'h0292_0105_9A);
        bus_read(A_STATUS, rd);
        vecs++; if (rd !== 32'h0000_0001) begin $display("[TB] FAIL valid_status: got %h expected 00000001", rd); errs++; end
        bus_read(A_DATA, rd);
        vecs++; if (rd !== 32'h0105_0292) begin $display("[TB] FAIL valid_data: got %h expected 01050292", rd); errs++; end
        bus_read(A_STATUS, rd);
        vecs++; if (rd !== 32'h0000_0000) begin $display("[TB] FAIL read_clears_valid: got %h expected 00000000", rd); errs++; end
    endtask

    task automatic test_negative_temp;
        logic [31:0] rd;
        acquire(40'h0292_8065_79, 32'h0);
        bus_read(A_DATA, rd);
        vecs++; if (rd !== 32'hFF9B_0292) begin $display("[TB] FAIL neg_temp: got %h expected ff9b0292", rd); errs++; end
        acquire(40'h0292_8000_14, 32'h0);
        bus_read(A_DATA, rd);
        vecs++; if (rd !== 32'h0000_0292) begin $display("[TB] FAIL neg_zero: got %h expected 00000292", rd); errs++; end
    endtask

    task automatic test_crc_error;
        logic [31:0] rd;
        acquire(40'h0292_0105_9B, 32'h0);
        bus_read(A_STATUS, rd);
        vecs++; if (rd !== 32'h0000_0102) begin $display("[TB] FAIL crc_status: got %h expected 00000102", rd); errs++; end
        bus_read(A_DATA, rd);
        vecs++; if (rd !== 32'h0000_0292) begin $display("[TB] FAIL crc_data_kept: got %h expected 00000292", rd); errs++; end
    endtask

    task automatic test_timeout;
        logic [31:0] rd;
        bit seen;
        bit found;
        int s;
        int elapsed;
        bus_write(A_CTRL, 32'h4);
        wait_start(5, seen);
        vecs++; if (seen !== 1'b1) begin $display("[TB] FAIL to_start: got no pulse expected coe_start"); errs++; end
        s = start_times[$];
        coe_busy = 1'b1;
        bus_read(A_STATUS, rd);
        coe_busy = 1'b0;
        vecs++; if (rd !== 32'h0000_011A) begin $display("[TB] FAIL busy_status: got %h expected 0000011a", rd); errs++; end
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            bus_read(A_STATUS, rd);
            if (rd[2]) found = 1'b1;
        end
        elapsed = cyc - s;
        vecs++; if (!found || elapsed < 190 || elapsed > 210) begin
            $display("[TB] FAIL timeout_time: got %0d cycles (found=%0d) expected 190..210", elapsed, found); errs++; end
        vecs++; if (rd !== 32'h0001_0106) begin $display("[TB] FAIL timeout_status: got %h expected 00010106", rd); errs++; end
        frame_data = 40'h0292_0105_9A; frame_valid = 1'b1;
        tick(1);
        frame_valid = 1'b0;
        tick(3);
        bus_read(A_STATUS, rd);
        vecs++; if (rd !== 32'h0001_0106) begin $display("[TB] FAIL late_frame_status: got %h expected 00010106", rd); errs++; end
        bus_read(A_DATA, rd);
        vecs++; if (rd !== 32'h0000_0292) begin $display("[TB] FAIL late_frame_data: got %h expected 00000292", rd); errs++; end
    endtask

    task automatic test_period;
        logic [31:0] rd;
        bit seen;
        int n;
        bus_write(A_PERIOD, 32'd1);
        bus_read(A_PERIOD, rd);
        vecs++; if (rd !== 32'd2) begin $display("[TB] FAIL period_clamp: got %0d expected 2", rd); errs++; end
        bus_write(A_PERIOD, 32'hABCD_0003);
        bus_read(A_PERIOD, rd);
        vecs++; if (rd !== 32'd3) begin $display("[TB] FAIL period_upper: got %h expected 00000003", rd); errs++; end
        bus_write(A_PERIOD, 32'd2);
        bus_write(A_CTRL, 32'h1);
        for (int k = 0; k < 3; k++) begin
            wait_start(45, seen);
            vecs++; if (seen !== 1'b1) begin $display("[TB] FAIL paced_start_%0d: got no pulse expected coe_start", k); errs++; end
            send_frame(40'h0292_0105_9A);
        end
        bus_read(A_CTRL, rd);
        vecs++; if (rd !== 32'h1) begin $display("[TB] FAIL ctrl_enable: got %h expected 00000001", rd); errs++; end
        bus_write(A_CTRL, 32'h0);
        n = start_times.size();
        vecs++; if (start_times[n-1] - start_times[n-2] != 20) begin
            $display("[TB] FAIL period_interval_a: got %0d expected 20", start_times[n-1] - start_times[n-2]); errs++; end
        vecs++; if (start_times[n-2] - start_times[n-3] != 20) begin
            $display("[TB] FAIL period_interval_b: got %0d expected 20", start_times[n-2] - start_times[n-3]); errs++; end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        bit seen;
        int c0;
        c0 = start_count;
        bus_write(A_CTRL, 32'h4);
        wait_start(5, seen);
        bus_write(A_CTRL, 32'h4);
        send_frame(40'h0292_0105_9A);
        tick(30);
        vecs++; if (start_count - c0 != 1) begin
            $display("[TB] FAIL trigger_in_wait: got %0d starts expected 1", start_count - c0); errs++; end
        bus_read(A_CTRL, rd);
        vecs++; if (rd !== 32'h0) begin $display("[TB] FAIL trigger_reads_zero: got %h expected 00000000", rd); errs++; end
    endtask

    task automatic test_irq;
        logic [31:0] rd;
        bus_write(A_STATUS, 32'h8000_0007);
        bus_write(A_CTRL, 32'h2);
        tick(2);
        vecs++; if (irq !== 1'b0) begin $display("[TB] FAIL irq_idle: got %b expected 0", irq); errs++; end
        bus_read(A_STATUS, rd);
        vecs++; if (rd !== 32'h0) begin $display("[TB] FAIL counters_cleared: got %h expected 00000000", rd); errs++; end
        acquire(40'h0292_0105_9A, 32'h2);
        tick(2);
        vecs++; if (irq !== 1'b1) begin $display("[TB] FAIL irq_on_valid: got %b expected 1", irq); errs++; end
        bus_write(A_STATUS, 32'h7);
        tick(2);
        vecs++; if (irq !== 1'b0) begin $display("[TB] FAIL irq_after_w1c: got %b expected 0", irq); errs++; end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd;
        bit seen;
        bus_write(A_PERIOD, 32'd5);
        bus_write(A_CTRL, 32'h7);
        wait_start(5, seen);
        vecs++; if (seen !== 1'b1) begin $display("[TB] FAIL mid_start: got no pulse expected coe_start"); errs++; end
        reset = 1'b1;
        tick(2);
        vecs++; if (coe_start !== 1'b0) begin $display("[TB] FAIL mid_reset_start: got %b expected 0", coe_start); errs++; end
        reset = 1'b0;
        frame_data = 40'h0292_0105_9A; frame_valid = 1'b1;
        tick(1);
        frame_valid = 1'b0;
        tick(3);
        bus_read(A_DATA, rd);
        vecs++; if (rd !== 32'h0) begin $display("[TB] FAIL mid_reset_data: got %h expected 00000000", rd); errs++; end
        bus_read(A_STATUS, rd);
        vecs++; if (rd !== 32'h0) begin $display("[TB] FAIL mid_reset_status: got %h expected 00000000", rd); errs++; end
        bus_read(A_CTRL, rd);
        vecs++; if (rd !== 32'h0) begin $display("[TB] FAIL mid_reset_ctrl: got %h expected 00000000", rd); errs++; end
        bus_read(A_PERIOD, rd);
        vecs++; if (rd !== 32'd2000) begin $display("[TB] FAIL mid_reset_period: got %0d expected 2000", rd); errs++; end
        vecs++; if (irq !== 1'b0 || coe_start !== 1'b0) begin
            $display("[TB] FAIL mid_reset_outputs: got irq=%b start=%b expected 0/0", irq, coe_start); errs++; end
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_negative_temp();
        test_crc_error();
        test_timeout();
        test_period();
        test_back_to_back();
        test_irq();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
